main_controller: RTL and testbench
==================================

// Module: main_controller
// PURPOSE
// Multicycle main control FSM for the MIPS-subset CPU.
// Consumes the decoded op/funct (lib_cpu OPECODE/FUNCT) and issues Moore-style control strobes.
// These strobes sequence the shared datapath: PC, IR, register file, ALU and unified instruction/data memory.
// Holds in memory states until the memory handshake completes.
// Traps (or skips) invalid encodings and counts retired instructions.
// PARAMETERS
// TRAP_ON_INVALID  1   1: invalid op/funct -> HALT; 0: treated as NOP (back to FETCH, still retired)
// RETIRE_W         32  width of retired-instruction counter
// PORTS
// clk          in   1         rising-edge clock
// rst_n        in   1         asynchronous reset, active low
// op           in   OPECODE   decoded opcode of IR contents (valid from DECODE on)
// funct        in   FUNCT     decoded funct field of IR contents
// zero         in   1         ALU zero flag (combinational, current cycle)
// mem_ready    in   1         memory access accepted/completed this cycle
// mem_req      out  1         memory access request
// iord         out  1         address mux: 0=PC, 1=ALUOut
// mem_write    out  1         memory write strobe (qualified by mem_req)
// ir_write     out  1         IR load enable
// reg_dst      out  1         write reg select: 0=rt, 1=rd
// mem_to_reg   out  1         writeback select: 0=ALUOut, 1=Data reg
// reg_write    out  1         register file write enable
// alu_src_a    out  1         0=PC, 1=A
// alu_src_b    out  2         00=B, 01=4, 10=SignImm, 11=SignImm<<2
// alu_control  out  3         AND=000 OR=001 ADD=010 SUB=110 SLT=111
// pc_src       out  2         00=ALUResult, 01=ALUOut, 10=jump target
// pc_en        out  1         PC load enable
// halted       out  1         1 while in HALT
// retired      out  RETIRE_W  count of completed instructions
// BEHAVIOUR
// - Reset (rst_n=0, async): state=FETCH, retired=0, halted=0.
// - Every other output is decoded from state alone and idles at 0; the FETCH strobes take effect only once rst_n releases.
// - Strobes not listed for a state are 0.
// - FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, ADD, pc_src=00.
//   ir_write=pc_en=mem_ready.
//   Stay in FETCH until mem_ready=1, then go to DECODE.
// - DECODE: alu_src_a=0, alu_src_b=11, ADD (branch target -> ALUOut).
//   Next state by op: LW/SW->MEMADR, RTYPE->EXECUTE, BEQ->BRANCH, ADDI->ADDIEXEC, J->JUMP, INVALID_OP->BAD.
// - MEMADR: alu_src_a=1, alu_src_b=10, ADD. Next: LW->MEMRD, SW->MEMWR.
// - MEMRD: mem_req=1, iord=1. Hold until mem_ready=1, then go to MEMWB.
// - MEMWR: mem_req=1, iord=1, mem_write=1. Hold until mem_ready=1, then retire and go to FETCH.
// - MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. Retire, then go to FETCH.
// - EXECUTE: alu_src_a=1, alu_src_b=00, alu_control from funct.
//   INVALID_FU -> BAD (no writeback); otherwise -> ALUWB.
// - ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1, alu_control held from funct. Retire, then go to FETCH.
// - BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_src=01, pc_en=zero. Retire, then go to FETCH.
// - ADDIEXEC: alu_src_a=1, alu_src_b=10, ADD. Next: ADDIWB.
// - ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1. Retire, then go to FETCH.
// - JUMP: pc_src=10, pc_en=1. Retire, then go to FETCH.
// - BAD: TRAP_ON_INVALID=1 -> HALT; TRAP_ON_INVALID=0 -> retire, go to FETCH, no side effects.
// - HALT: all strobes 0, halted=1. Only reset exits HALT.
// - Retire = retired+1 on the final cycle of an instruction; the counter wraps modulo 2^RETIRE_W.
// - mem_ready outside a mem_req state is ignored.
// - Reset mid-instruction aborts it: no partial reg_write or mem_write is issued afterwards.
// - Latency with mem_ready tied 1: LW=5, SW=4, R/ADDI=4, BEQ/J=3 cycles.
// TESTING
// - mem_ready=1; LW then SW -> 5+4 cycles; LW cycles FETCH,DECODE,MEMADR,MEMRD,MEMWB; retired=2.
// - RTYPE SUB -> EXECUTE with alu_control=110; ALUWB reg_dst=1, reg_write=1 for exactly 1 cycle.
// - BEQ, zero=1 -> pc_en=1, pc_src=01 in BRANCH; zero=0 -> pc_en=0; retired increments in both cases.
// - FETCH with mem_ready low for 3 cycles -> state held, ir_write=0, pc_en=0; ir_write=pc_en=1 on the 4th cycle.
// - op=INVALID_OP with TRAP_ON_INVALID=1 -> HALT, halted=1, strobes 0 for 10 cycles; rst_n pulse -> FETCH, retired=0.
// - rst_n asserted during MEMWR (mem_ready=0) -> immediately mem_write=0, state=FETCH.
// - RETIRE_W=2, 5 J instructions -> retired wraps 3->0->1.

Source files
------------

// File: rtl/main_controller_if.sv
// Decoded instruction fields plus the control strobes between the main FSM and the datapath.
// The lib_cpu types are kept here so the interface and the controller share one definition.
package lib_cpu;

  typedef enum logic [2:0] {
    OP_LW      = 3'd0,
    OP_SW      = 3'd1,
    OP_RTYPE   = 3'd2,
    OP_BEQ     = 3'd3,
    OP_ADDI    = 3'd4,
    OP_J       = 3'd5,
    INVALID_OP = 3'd7
  } OPECODE;

  typedef enum logic [2:0] {
    FU_ADD     = 3'd0,
    FU_SUB     = 3'd1,
    FU_AND     = 3'd2,
    FU_OR      = 3'd3,
    FU_SLT     = 3'd4,
    INVALID_FU = 3'd7
  } FUNCT;

endpackage

interface main_controller_if #(
  parameter int RETIRE_W = 32
);
  import lib_cpu::*;

  OPECODE              op;
  FUNCT                funct;
  logic                zero;
  logic                mem_ready;
  logic                mem_req;
  logic                iord;
  logic                mem_write;
  logic                ir_write;
  logic                reg_dst;
  logic                mem_to_reg;
  logic                reg_write;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [2:0]          alu_control;
  logic [1:0]          pc_src;
  logic                pc_en;
  logic                halted;
  logic [RETIRE_W-1:0] retired;

  modport master (
    input  op, funct, zero, mem_ready,
    output mem_req, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_control, pc_src, pc_en, halted, retired
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  mem_req, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_control, pc_src, pc_en, halted, retired
  );

endinterface

// File: rtl/main_controller.sv
// Multicycle main control FSM for the MIPS-subset CPU: Moore-style strobes for a shared
// PC/IR/regfile/ALU/memory datapath, memory-handshake stalls, invalid-encoding trap, retire counter.
module main_controller
  import lib_cpu::*;
#(
  parameter bit TRAP_ON_INVALID = 1'b1,
  parameter int RETIRE_W        = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  main_controller_if.master  bus
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWR, MEMWB, EXECUTE, ALUWB,
    BRANCH, ADDIEXEC, ADDIWB, JUMP, BAD, HALT
  } state_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t              state_reg, state_next;
  logic [RETIRE_W-1:0] retired_reg;
  logic [2:0]          alu_hold_reg;
  logic                retire;
  logic [2:0]          funct_alu;
  logic                funct_ok;

  always_comb begin
    funct_alu = ALU_AND;
    funct_ok  = 1'b1;
    case (bus.funct)
      FU_ADD:  funct_alu = ALU_ADD;
      FU_SUB:  funct_alu = ALU_SUB;
      FU_AND:  funct_alu = ALU_AND;
      FU_OR:   funct_alu = ALU_OR;
      FU_SLT:  funct_alu = ALU_SLT;
      default: funct_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= FETCH;
      retired_reg  <= '0;
      alu_hold_reg <= ALU_AND;
    end else begin
      state_reg <= state_next;
      if (retire) begin
        retired_reg <= retired_reg + RETIRE_W'(1);
      end
      // ALUWB keeps driving the operation chosen in EXECUTE
      if (state_reg == EXECUTE) begin
        alu_hold_reg <= funct_alu;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    retire     = 1'b0;
    case (state_reg)
      FETCH: begin
        if (bus.mem_ready) state_next = DECODE;
      end
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = EXECUTE;
          OP_BEQ:       state_next = BRANCH;
          OP_ADDI:      state_next = ADDIEXEC;
          OP_J:         state_next = JUMP;
          default:      state_next = BAD;
        endcase
      end
      MEMADR: begin
        state_next = (bus.op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        if (bus.mem_ready) state_next = MEMWB;
      end
      MEMWR: begin
        if (bus.mem_ready) begin
          state_next = FETCH;
          retire     = 1'b1;
        end
      end
      EXECUTE: begin
        state_next = funct_ok ? ALUWB : BAD;
      end
      ADDIEXEC: begin
        state_next = ADDIWB;
      end
      MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: begin
        state_next = FETCH;
        retire     = 1'b1;
      end
      BAD: begin
        if (TRAP_ON_INVALID) begin
          state_next = HALT;
        end else begin
          state_next = FETCH;
          retire     = 1'b1;
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  // Strobes stay low while rst_n is held so nothing reaches the datapath before release
  always_comb begin
    bus.mem_req     = 1'b0;
    bus.iord        = 1'b0;
    bus.mem_write   = 1'b0;
    bus.ir_write    = 1'b0;
    bus.reg_dst     = 1'b0;
    bus.mem_to_reg  = 1'b0;
    bus.reg_write   = 1'b0;
    bus.alu_src_a   = 1'b0;
    bus.alu_src_b   = 2'b00;
    bus.alu_control = ALU_AND;
    bus.pc_src      = 2'b00;
    bus.pc_en       = 1'b0;
    bus.halted      = 1'b0;
    if (rst_n) begin
      case (state_reg)
        FETCH: begin
          bus.mem_req     = 1'b1;
          bus.alu_src_b   = 2'b01;
          bus.alu_control = ALU_ADD;
          bus.ir_write    = bus.mem_ready;
          bus.pc_en       = bus.mem_ready;
        end
        DECODE: begin
          bus.alu_src_b   = 2'b11;
          bus.alu_control = ALU_ADD;
        end
        MEMADR, ADDIEXEC: begin
          bus.alu_src_a   = 1'b1;
          bus.alu_src_b   = 2'b10;
          bus.alu_control = ALU_ADD;
        end
        MEMRD: begin
          bus.mem_req = 1'b1;
          bus.iord    = 1'b1;
        end
        MEMWR: begin
          bus.mem_req   = 1'b1;
          bus.iord      = 1'b1;
          bus.mem_write = 1'b1;
        end
        MEMWB: begin
          bus.mem_to_reg = 1'b1;
          bus.reg_write  = 1'b1;
        end
        EXECUTE: begin
          bus.alu_src_a   = 1'b1;
          bus.alu_control = funct_alu;
        end
        ALUWB: begin
          bus.reg_dst     = 1'b1;
          bus.reg_write   = 1'b1;
          bus.alu_control = alu_hold_reg;
        end
        BRANCH: begin
          bus.alu_src_a   = 1'b1;
          bus.alu_control = ALU_SUB;
          bus.pc_src      = 2'b01;
          bus.pc_en       = bus.zero;
        end
        ADDIWB: begin
          bus.reg_write = 1'b1;
        end
        JUMP: begin
          bus.pc_src = 2'b10;
          bus.pc_en  = 1'b1;
        end
        HALT: begin
          bus.halted = 1'b1;
        end
        default: begin
          bus.halted = 1'b0;
        end
      endcase
    end
  end

  assign bus.retired = retired_reg;

endmodule

// File: tb/tb_main_controller.sv
// Bench for main_controller: hand-written vector table plus randomized instruction streams
// checked cycle by cycle against an instruction-level model of the control strobes.
module tb_main_controller;
  import lib_cpu::*;

  logic   clk = 1'b0;
  logic   rst1_n, rst2_n;
  OPECODE op_d;
  FUNCT   funct_d;
  logic   zero_d, mr_d;

  always #5 clk = ~clk;

  main_controller_if #(.RETIRE_W(32)) bus1();
  main_controller_if #(.RETIRE_W(2))  bus2();

  assign bus1.op = op_d;  assign bus1.funct = funct_d;
  assign bus1.zero = zero_d;  assign bus1.mem_ready = mr_d;
  assign bus2.op = op_d;  assign bus2.funct = funct_d;
  assign bus2.zero = zero_d;  assign bus2.mem_ready = mr_d;

  // dut1 traps invalid encodings; dut2 skips them and has a 2-bit retire counter
  main_controller #(.TRAP_ON_INVALID(1'b1), .RETIRE_W(32)) dut1 (
    .clk(clk), .rst_n(rst1_n), .bus(bus1));
  main_controller #(.TRAP_ON_INVALID(1'b0), .RETIRE_W(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .bus(bus2));

  logic [16:0] out1, out2;
  assign out1 = {bus1.mem_req, bus1.iord, bus1.mem_write, bus1.ir_write, bus1.reg_dst,
                 bus1.mem_to_reg, bus1.reg_write, bus1.alu_src_a, bus1.alu_src_b,
                 bus1.alu_control, bus1.pc_src, bus1.pc_en, bus1.halted};
  assign out2 = {bus2.mem_req, bus2.iord, bus2.mem_write, bus2.ir_write, bus2.reg_dst,
                 bus2.mem_to_reg, bus2.reg_write, bus2.alu_src_a, bus2.alu_src_b,
                 bus2.alu_control, bus2.pc_src, bus2.pc_en, bus2.halted};

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_ret [2];

  typedef struct {
    bit          mr;
    logic [16:0] exp;
    string       st;
  } cyc_t;
  cyc_t q[$];

  typedef struct {
    OPECODE o;
    FUNCT   f;
    bit     z;
    int     fs;
    int     ms;
    int     lat;
    string  name;
  } vec_t;

  function automatic logic [16:0] sig(input bit mreq, input bit iord, input bit mw,
                                      input bit irw, input bit rd, input bit m2r,
                                      input bit rw, input bit a, input bit [1:0] b,
                                      input bit [2:0] alu, input bit [1:0] pcs,
                                      input bit pce, input bit h);
    return {mreq, iord, mw, irw, rd, m2r, rw, a, b, alu, pcs, pce, h};
  endfunction

  function automatic logic [16:0] out_of(input bit sel);
    return sel ? out2 : out1;
  endfunction

  function automatic logic [31:0] ret_of(input bit sel);
    return sel ? {30'b0, bus2.retired} : bus1.retired;
  endfunction

  function automatic logic [31:0] ret_mask(input bit sel, input logic [31:0] v);
    return sel ? (v & 32'd3) : v;
  endfunction

  function automatic bit [2:0] alu_of(input FUNCT f);
    case (f)
      FU_ADD:  return 3'b010;
      FU_SUB:  return 3'b110;
      FU_AND:  return 3'b000;
      FU_OR:   return 3'b001;
      FU_SLT:  return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  function automatic bit funct_ok(input FUNCT f);
    return f inside {FU_ADD, FU_SUB, FU_AND, FU_OR, FU_SLT};
  endfunction

  function automatic bit is_bad(input OPECODE o, input FUNCT f);
    return !(o inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J}) ||
           (o == OP_RTYPE && !funct_ok(f));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic bit rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected per-cycle strobes for one instruction, derived from its class and stall counts
  task automatic build(input OPECODE o, input FUNCT f, input bit z, input int fs, input int ms);
    q.delete();
    for (int i = 0; i < fs; i++)
      q.push_back('{0, sig(1,0,0,0,0,0,0,0,2'b01,3'b010,2'b00,0,0), "fetch_wait"});
    q.push_back('{1, sig(1,0,0,1,0,0,0,0,2'b01,3'b010,2'b00,1,0), "fetch"});
    q.push_back('{rnd(), sig(0,0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,0), "decode"});
    if (o == OP_LW || o == OP_SW) begin
      bit w = (o == OP_SW);
      q.push_back('{rnd(), sig(0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0), "memadr"});
      for (int i = 0; i < ms; i++)
        q.push_back('{0, sig(1,1,w,0,0,0,0,0,2'b00,3'b000,2'b00,0,0), "mem_wait"});
      q.push_back('{1, sig(1,1,w,0,0,0,0,0,2'b00,3'b000,2'b00,0,0), "mem"});
      if (o == OP_LW)
        q.push_back('{rnd(), sig(0,0,0,0,0,1,1,0,2'b00,3'b000,2'b00,0,0), "memwb"});
    end else if (o == OP_RTYPE) begin
      q.push_back('{rnd(), sig(0,0,0,0,0,0,0,1,2'b00,alu_of(f),2'b00,0,0), "execute"});
      if (funct_ok(f))
        q.push_back('{rnd(), sig(0,0,0,0,1,0,1,0,2'b00,alu_of(f),2'b00,0,0), "aluwb"});
      else
        q.push_back('{rnd(), sig(0,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,0), "bad"});
    end else if (o == OP_BEQ) begin
      q.push_back('{rnd(), sig(0,0,0,0,0,0,0,1,2'b00,3'b110,2'b01,z,0), "branch"});
    end else if (o == OP_ADDI) begin
      q.push_back('{rnd(), sig(0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0), "addiexec"});
      q.push_back('{rnd(), sig(0,0,0,0,0,0,1,0,2'b00,3'b000,2'b00,0,0), "addiwb"});
    end else if (o == OP_J) begin
      q.push_back('{rnd(), sig(0,0,0,0,0,0,0,0,2'b00,3'b000,2'b10,1,0), "jump"});
    end else begin
      q.push_back('{rnd(), sig(0,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,0), "bad"});
    end
  endtask

  // Applies one instruction; stop_at >= 0 abandons it after that many cycles
  task automatic run_instr(input bit sel, input OPECODE o, input FUNCT f, input bit z,
                           input int fs, input int ms, input int stop_at, output int lat);
    logic [31:0] r0;
    int n;
    bit retires;
    build(o, f, z, fs, ms);
    op_d = o;  funct_d = f;  zero_d = z;
    lat = 0;
    r0 = ret_of(sel);
    n = (stop_at >= 0) ? stop_at : q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mr_d = q[i].mr;
      #1 chk($sformatf("dut%0d_%s_c%0d", sel + 1, q[i].st, i), out_of(sel), q[i].exp);
      @(posedge clk);
      #1;
      if (lat == 0 && ret_of(sel) != r0) lat = i + 1;
    end
    if (stop_at < 0) begin
      retires = !(is_bad(o, f) && !sel);
      if (retires) exp_ret[sel] = exp_ret[sel] + 1;
      chk("latency", lat, retires ? q.size() : 0);
      chk("retired", ret_of(sel), ret_mask(sel, exp_ret[sel]));
    end
    $display("instr dut%0d op=%s funct=%s z=%0d fs=%0d ms=%0d lat=%0d retired=%0d",
             sel + 1, o.name(), f.name(), z, fs, ms, lat, ret_of(sel));
  endtask

  vec_t   tbl [11];
  OPECODE ops_all [7] = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J, INVALID_OP};
  FUNCT   fus_all [6] = '{FU_ADD, FU_SUB, FU_AND, FU_OR, FU_SLT, INVALID_FU};
  logic [31:0] wrap_want [5] = '{32'd1, 32'd2, 32'd3, 32'd0, 32'd1};

  initial begin
    int lat;
    tbl[0]  = '{OP_LW,    FU_ADD, 0, 0, 0, 5, "lw"};
    tbl[1]  = '{OP_SW,    FU_ADD, 0, 0, 0, 4, "sw"};
    tbl[2]  = '{OP_RTYPE, FU_SUB, 0, 0, 0, 4, "r_sub"};
    tbl[3]  = '{OP_RTYPE, FU_SLT, 0, 0, 0, 4, "r_slt"};
    tbl[4]  = '{OP_BEQ,   FU_ADD, 1, 0, 0, 3, "beq_taken"};
    tbl[5]  = '{OP_BEQ,   FU_ADD, 0, 0, 0, 3, "beq_not"};
    tbl[6]  = '{OP_ADDI,  FU_ADD, 0, 0, 0, 4, "addi"};
    tbl[7]  = '{OP_J,     FU_ADD, 0, 0, 0, 3, "j"};
    tbl[8]  = '{OP_J,     FU_OR,  0, 3, 0, 6, "j_fetch_stall3"};
    tbl[9]  = '{OP_LW,    FU_AND, 0, 1, 2, 8, "lw_stalls"};
    tbl[10] = '{OP_SW,    FU_ADD, 0, 0, 2, 6, "sw_stall2"};

    rst1_n = 1'b0;  rst2_n = 1'b0;
    op_d = OP_LW;  funct_d = FU_ADD;  zero_d = 1'b0;  mr_d = 1'b0;
    exp_ret[0] = 0;  exp_ret[1] = 0;

    // Reset: outputs idle at 0 even with mem_ready high
    @(negedge clk);
    @(negedge clk);
    mr_d = 1'b1;
    #1;
    chk("reset_out1", out1, 17'd0);
    chk("reset_out2", out2, 17'd0);
    chk("reset_ret1", ret_of(0), 0);
    chk("reset_ret2", ret_of(1), 0);
    @(negedge clk);
    mr_d = 1'b0;  rst1_n = 1'b1;  rst2_n = 1'b1;
    #1 chk("release_fetch", out1, sig(1,0,0,0,0,0,0,0,2'b01,3'b010,2'b00,0,0));

    foreach (tbl[i]) begin
      run_instr(0, tbl[i].o, tbl[i].f, tbl[i].z, tbl[i].fs, tbl[i].ms, -1, lat);
      chk({tbl[i].name, "_lat"}, lat, tbl[i].lat);
    end
    chk("table_retired", ret_of(0), 11);

    // Invalid opcode traps into HALT until reset
    run_instr(0, INVALID_OP, FU_ADD, 0, 0, 0, -1, lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      mr_d = rnd();
      #1 chk($sformatf("halt_c%0d", i), out1, sig(0,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,1));
    end
    chk("halt_retired", ret_of(0), 11);
    @(negedge clk);
    rst1_n = 1'b0;
    #1;
    chk("halt_reset_out", out1, 17'd0);
    chk("halt_reset_ret", ret_of(0), 0);
    exp_ret[0] = 0;
    @(negedge clk);
    mr_d = 1'b0;  rst1_n = 1'b1;
    #1 chk("halt_exit_fetch", out1, sig(1,0,0,0,0,0,0,0,2'b01,3'b010,2'b00,0,0));

    // Reset while a store is waiting on memory
    run_instr(0, OP_J, FU_ADD, 0, 0, 0, -1, lat);
    run_instr(0, OP_SW, FU_ADD, 0, 0, 9, 5, lat);
    @(negedge clk);
    mr_d = 1'b0;
    #1 chk("memwr_wait", out1, sig(1,1,1,0,0,0,0,0,2'b00,3'b000,2'b00,0,0));
    #1 rst1_n = 1'b0;
    #1 chk("memwr_reset_out", out1, 17'd0);
    chk("memwr_reset_ret", ret_of(0), 0);
    exp_ret[0] = 0;
    @(negedge clk);
    rst1_n = 1'b1;
    #1 chk("memwr_reset_fetch", out1, sig(1,0,0,0,0,0,0,0,2'b01,3'b010,2'b00,0,0));

    for (int k = 0; k < 40; k++) begin
      run_instr(0, ops_all[$urandom_range(0, 5)], fus_all[$urandom_range(0, 4)], rnd(),
                $urandom_range(0, 2), $urandom_range(0, 2), -1, lat);
    end

    // Invalid funct also traps
    run_instr(0, OP_RTYPE, INVALID_FU, 0, 0, 0, -1, lat);
    @(negedge clk);
    #1 chk("badfunct_halted", out1, sig(0,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,1));

    // dut2: counter wraps modulo 4
    @(negedge clk);
    rst2_n = 1'b0;
    mr_d = 1'b0;
    @(negedge clk);
    rst2_n = 1'b1;
    exp_ret[1] = 0;
    for (int k = 0; k < 5; k++) begin
      run_instr(1, OP_J, FU_ADD, 0, 0, 0, -1, lat);
      chk($sformatf("wrap_%0d", k), ret_of(1), wrap_want[k]);
    end

    // dut2: invalid encodings are skipped and still retire
    run_instr(1, INVALID_OP, FU_ADD, 0, 0, 0, -1, lat);
    chk("skip_op_lat", lat, 3);
    run_instr(1, OP_RTYPE, INVALID_FU, 0, 0, 0, -1, lat);
    chk("skip_fu_lat", lat, 4);
    for (int k = 0; k < 40; k++) begin
      run_instr(1, ops_all[$urandom_range(0, 6)], fus_all[$urandom_range(0, 5)], rnd(),
                $urandom_range(0, 2), $urandom_range(0, 2), -1, lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
